// File: rtl/multicycle_alu.sv
// multicycle_alu: multi-cycle execute unit. One-cycle logic/arith ops, 1-bit/cycle shifts, optional shift-add MUL.
// Ports: clk, reset (async, active-high), start_i, ALU_Operation_i[3:0], A_i, B_i -> busy_o, done_o, ALU_Result_o, Zero_o.
// Config: define MULT_EN to build the 32-cycle multiply for op 1011; otherwise 1011 returns 0 in one cycle.
module multicycle_alu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [3:0]            ALU_Operation_i,
    input  logic [DATA_WIDTH-1:0] A_i,
    input  logic [DATA_WIDTH-1:0] B_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] ALU_Result_o,
    output logic                  Zero_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [5:0] cnt, cnt_n;
    logic [3:0] op, op_n;
    logic [DATA_WIDTH-1:0] work, work_n, res, res_n, quick, step, run_res, run_work;
    logic accept, is_shift, start_mul, iterate;
    assign accept   = start_i && state != RUN;
    assign is_shift = ALU_Operation_i inside {4'h5, 4'h6, 4'h7};
    assign iterate  = (is_shift && B_i[4:0] != 5'd0) || start_mul;
    always_comb begin
        quick = '0;
        case (ALU_Operation_i)
            4'h0: quick = A_i + B_i;
            4'h1: quick = A_i - B_i;
            4'h2: quick = A_i & B_i;
            4'h3: quick = A_i | B_i;
            4'h4: quick = A_i ^ B_i;
            4'h5, 4'h6, 4'h7: quick = A_i;  // only reached with shamt = 0
            4'h8: quick = {{(DATA_WIDTH-1){1'b0}}, $signed(A_i) < $signed(B_i)};
            4'h9: quick = {{(DATA_WIDTH-1){1'b0}}, A_i < B_i};
            4'hA: quick = B_i;
            default: quick = '0;
        endcase
    end
    assign step = op == 4'h5 ? work << 1 :
                  op == 4'h6 ? work >> 1 : {work[DATA_WIDTH-1], work[DATA_WIDTH-1:1]};
`ifdef MULT_EN
    logic [DATA_WIDTH-1:0] mplier, mplier_n, acc, acc_n, acc_sum;
    assign start_mul = ALU_Operation_i == 4'hB;
    assign acc_sum   = acc + (mplier[0] ? work : '0);
    assign run_res   = op == 4'hB ? acc_sum : step;
    // The multiplicand lives in the shared working register.
    assign run_work  = op == 4'hB ? work << 1 : step;
    always_comb begin
        mplier_n = mplier;
        acc_n    = acc;
        if (state == RUN) begin
            mplier_n = mplier >> 1;
            acc_n    = acc_sum;
        end else if (accept) begin
            mplier_n = B_i;
            acc_n    = '0;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mplier <= '0;
            acc    <= '0;
        end else begin
            mplier <= mplier_n;
            acc    <= acc_n;
        end
    end
`else
    assign start_mul = 1'b0;
    assign run_res   = step;
    assign run_work  = step;
`endif
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        op_n    = op;
        work_n  = work;
        res_n   = res;
        if (state == RUN) begin
            cnt_n  = cnt - 6'd1;
            work_n = run_work;
            if (cnt == 6'd1) begin
                state_n = DONE;
                res_n   = run_res;
            end
        end else if (accept) begin
            op_n = ALU_Operation_i;
            if (iterate) begin
                state_n = RUN;
                work_n  = A_i;
                cnt_n   = start_mul ? 6'd32 : {1'b0, B_i[4:0]};
            end else begin
                state_n = DONE;
                res_n   = quick;
            end
        end else begin
            state_n = IDLE;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            op    <= '0;
            work  <= '0;
            res   <= '0;
            Zero_o <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            op    <= op_n;
            work  <= work_n;
            res   <= res_n;
            Zero_o <= res_n == '0;
        end
    end
    assign busy_o       = state == RUN;
    assign done_o       = state == DONE;
    assign ALU_Result_o = res;
endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: directed bench for multicycle_alu with a latency/result model and per-cycle compare.
module tb_multicycle_alu;
    logic clk = 0, reset = 0, start_i = 0;
    logic [3:0] op = 0;
    logic [31:0] a = 0, b = 0;
    logic busy_o, done_o, Zero_o;
    logic [31:0] ALU_Result_o;
    int n_vec = 0, n_err = 0;
    int m_rem = 0;
    logic m_done = 0;
    logic [31:0] m_res = 0, m_pend = 0;

    multicycle_alu #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .ALU_Operation_i(op),
        .A_i(a), .B_i(b), .busy_o(busy_o), .done_o(done_o),
        .ALU_Result_o(ALU_Result_o), .Zero_o(Zero_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f_res(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        case (o)
            4'h0: return x + y;
            4'h1: return x - y;
            4'h2: return x & y;
            4'h3: return x | y;
            4'h4: return x ^ y;
            4'h5: return x << y[4:0];
            4'h6: return x >> y[4:0];
            4'h7: return $unsigned($signed(x) >>> y[4:0]);
            4'h8: return {31'b0, $signed(x) < $signed(y)};
            4'h9: return {31'b0, x < y};
            4'hA: return y;
`ifdef MULT_EN
            4'hB: return x * y;
`endif
            default: return 32'h0;
        endcase
    endfunction

    function automatic int f_lat(input logic [3:0] o, input logic [31:0] y);
        if (o inside {4'h5, 4'h6, 4'h7}) return int'(y[4:0]) + 1;
`ifdef MULT_EN
        if (o == 4'hB) return 33;
`endif
        return 1;
    endfunction

    // Model: one request in flight, tracked only by edges remaining until done.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_rem  <= 0;
            m_done <= 0;
            m_res  <= 0;
        end else if (m_rem > 0) begin
            m_rem  <= m_rem - 1;
            m_done <= m_rem == 1;
            if (m_rem == 1) m_res <= m_pend;
        end else if (start_i) begin
            m_rem  <= f_lat(op, b) - 1;
            m_done <= f_lat(op, b) == 1;
            if (f_lat(op, b) == 1) m_res <= f_res(op, a, b);
            else m_pend <= f_res(op, a, b);
        end else begin
            m_done <= 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m_done", {31'b0, done_o}, {31'b0, m_done});
        chk("m_busy", {31'b0, busy_o}, {31'b0, m_rem > 0});
        chk("m_result", ALU_Result_o, m_res);
        chk("m_zero", {31'b0, Zero_o}, {31'b0, m_res == 0});
    end

    // Called at a negedge; returns at the negedge where done_o is seen.
    task automatic run(input string name, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp, input int lat);
        int k, nb;
        nb = 0;
        start_i = 1; op = o; a = x; b = y;
        for (k = 1; k <= 100; k++) begin
            @(negedge clk);
            start_i = 0; a = $urandom; b = $urandom;
            if (done_o) break;
            if (busy_o) nb++;
        end
        chk({name, " latency"}, k, lat);
        chk({name, " busy cycles"}, nb, lat - 1);
        chk({name, " result"}, ALU_Result_o, exp);
    endtask

    initial begin
        int nd;
        #1 reset = 1;
        repeat (2) @(negedge clk);
        chk("reset busy", {31'b0, busy_o}, 0);
        chk("reset done", {31'b0, done_o}, 0);
        chk("reset result", ALU_Result_o, 0);
        chk("reset zero", {31'b0, Zero_o}, 1);
        reset = 0;
        @(negedge clk);
        run("add", 4'h0, 5, 7, 12, 1);
        chk("add zero", {31'b0, Zero_o}, 0);
        @(negedge clk);
        start_i = 1; op = 4'h1; a = 5; b = 5;
        @(negedge clk);
        chk("b2b sub done", {31'b0, done_o}, 1);
        chk("b2b sub result", ALU_Result_o, 0);
        op = 4'h2; a = 32'hF0; b = 32'h0F;
        @(negedge clk);
        start_i = 0;
        chk("b2b and done", {31'b0, done_o}, 1);
        chk("b2b and result", ALU_Result_o, 0);
        chk("b2b and zero", {31'b0, Zero_o}, 1);
        @(negedge clk);
        run("sra", 4'h7, 32'h80000000, 4, 32'hF8000000, 5);
        run("sll0", 4'h5, 32'hDEADBEEF, 32'hFFFFFFE0, 32'hDEADBEEF, 1);
        run("xor", 4'h4, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 1);
        run("or", 4'h3, 32'hF0, 32'h0F, 32'hFF, 1);
        run("slt", 4'h8, 32'hFFFFFFFF, 1, 1, 1);
        run("sltu", 4'h9, 32'hFFFFFFFF, 1, 0, 1);
        run("passb", 4'hA, 32'h1, 32'h12345000, 32'h12345000, 1);
        run("bad op", 4'hF, 32'h3, 32'h4, 0, 1);
        run("add wrap", 4'h0, 32'hFFFFFFFF, 1, 0, 1);
        run("sub wrap", 4'h1, 0, 1, 32'hFFFFFFFF, 1);
        run("srl31", 4'h6, 32'h80000000, 31, 1, 32);
`ifdef MULT_EN
        run("mul", 4'hB, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 33);
`else
        run("mul", 4'hB, 32'h0000FFFF, 32'h00010001, 0, 1);
`endif
        @(negedge clk);
        start_i = 1; op = 4'h6; a = 32'h12345678; b = 8;
        @(negedge clk);
        start_i = 0;
        nd = done_o ? 1 : 0;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            start_i = i == 1; op = 4'h0; a = 1; b = 1;
            if (done_o) nd++;
        end
        start_i = 0;
        chk("ignored start done count", nd, 1);
        chk("ignored start result", ALU_Result_o, 32'h00123456);
        @(negedge clk);
        start_i = 1; op = 4'h5; a = 1; b = 10;
        repeat (3) @(negedge clk);
        start_i = 0;
        #2 reset = 1;
        #1;
        chk("abort busy", {31'b0, busy_o}, 0);
        chk("abort done", {31'b0, done_o}, 0);
        chk("abort result", ALU_Result_o, 0);
        chk("abort zero", {31'b0, Zero_o}, 1);
        @(negedge clk);
        reset = 0;
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done_o) nd++;
        end
        chk("abort no done", nd, 0);
        run("add after abort", 4'h0, 1, 1, 2, 1);
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
